// File: rtl/dpram_pkg.sv
// Shared constants and byte helpers for the parametrised dual-port RAM.
// Optional parity storage is enabled by defining DPRAM_PARITY_EN.
package dpram_pkg;

  localparam int BYTE_W = 8;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] data_byte);
    return ^data_byte;
  endfunction

  function automatic logic [BYTE_W-1:0] byte_merge(input logic [BYTE_W-1:0] old_byte,
                                                   input logic [BYTE_W-1:0] new_byte,
                                                   input logic              be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dpram_if.sv
// Two-port RAM bus: request fields per port, registered responses one cycle later.
// perr_* / perr_inj_a exist only when DPRAM_PARITY_EN is defined.
interface dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  import dpram_pkg::*;

  // Handshake: no backpressure. re_x/we_x are accepted on every rising edge;
  // rvalid_x is high exactly one cycle after an accepted re_x, and rdata_x is
  // zero whenever rvalid_x is low. coll/oob_x/perr_x align with that cycle.
  logic [ADDR_W-1:0]        addr_a, addr_b;
  logic [DATA_W-1:0]        wdata_a, wdata_b;
  logic [DATA_W/BYTE_W-1:0] be_a, be_b;
  logic                     we_a, we_b;
  logic                     re_a, re_b;
  logic [DATA_W-1:0]        rdata_a, rdata_b;
  logic                     rvalid_a, rvalid_b;
  logic                     coll;
  logic                     oob_a, oob_b;
`ifdef DPRAM_PARITY_EN
  logic                     perr_a, perr_b;
  logic                     perr_inj_a;
`endif

  modport master (
    output addr_a, addr_b, wdata_a, wdata_b, be_a, be_b, we_a, we_b, re_a, re_b,
`ifdef DPRAM_PARITY_EN
    output perr_inj_a,
    input  perr_a, perr_b,
`endif
    input  rdata_a, rdata_b, rvalid_a, rvalid_b, coll, oob_a, oob_b
  );

  modport slave (
    input  addr_a, addr_b, wdata_a, wdata_b, be_a, be_b, we_a, we_b, re_a, re_b,
`ifdef DPRAM_PARITY_EN
    input  perr_inj_a,
    output perr_a, perr_b,
`endif
    output rdata_a, rdata_b, rvalid_a, rvalid_b, coll, oob_a, oob_b
  );

endinterface

// File: rtl/dpram_rport.sv
// One read port: forwards same-cycle writes from both ports into the returned word
// and registers rdata/rvalid/oob (and perr when DPRAM_PARITY_EN is defined).
module dpram_rport
  import dpram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     re,
  input  logic                     acc,
  input  logic                     in_range,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        mem_word,
`ifdef DPRAM_PARITY_EN
  input  logic [DATA_W/BYTE_W-1:0] mem_par,
  output logic                     perr,
`endif
  input  logic                     wr_a,
  input  logic [ADDR_W-1:0]        waddr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  input  logic [DATA_W/BYTE_W-1:0] be_a,
  input  logic                     wr_b,
  input  logic [ADDR_W-1:0]        waddr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  input  logic [DATA_W/BYTE_W-1:0] be_b,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     oob
);

  localparam int NB = DATA_W / BYTE_W;

  logic              hit_a, hit_b;
  logic [DATA_W-1:0] merged;

  // B is merged first so A overwrites it byte-wise, matching the array arbitration.
  always_comb begin
    hit_a  = wr_a && (waddr_a == raddr);
    hit_b  = wr_b && (waddr_b == raddr);
    merged = mem_word;
    for (int i = 0; i < NB; i++) begin
      merged[i*BYTE_W +: BYTE_W] = byte_merge(merged[i*BYTE_W +: BYTE_W],
                                              wdata_b[i*BYTE_W +: BYTE_W], hit_b && be_b[i]);
      merged[i*BYTE_W +: BYTE_W] = byte_merge(merged[i*BYTE_W +: BYTE_W],
                                              wdata_a[i*BYTE_W +: BYTE_W], hit_a && be_a[i]);
    end
  end

`ifdef DPRAM_PARITY_EN
  logic par_bad;

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      par_bad = par_bad | (byte_parity(mem_word[i*BYTE_W +: BYTE_W]) != mem_par[i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      oob    <= 1'b0;
`ifdef DPRAM_PARITY_EN
      perr   <= 1'b0;
`endif
    end else begin
      rvalid <= re;
      oob    <= acc && !in_range;
      rdata  <= (re && in_range) ? merged : '0;
`ifdef DPRAM_PARITY_EN
      // Forwarded words carry fresh parity, so only pure array reads can flag.
      perr   <= re && in_range && !hit_a && !hit_b && par_bad;
`endif
    end
  end

endmodule

// File: rtl/dpram_param.sv
// Parametrised true dual-port RAM: owns the array and A-over-B write arbitration.
// Define DPRAM_PARITY_EN to store and check one even-parity bit per byte.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic   clk,
  input  logic   rst_n,
  dpram_if.slave bus
);

  localparam int              NB      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_a, in_b, wr_a, wr_b, same_addr;
  logic [DATA_W-1:0] word_a, word_b;

  assign in_a      = {1'b0, bus.addr_a} < DEPTH_L;
  assign in_b      = {1'b0, bus.addr_b} < DEPTH_L;
  assign same_addr = bus.addr_a == bus.addr_b;
  // Requests seen while in reset never touch the array.
  assign wr_a      = rst_n && bus.we_a && in_a;
  assign wr_b      = rst_n && bus.we_b && in_b;
  assign word_a    = in_a ? mem[bus.addr_a] : '0;
  assign word_b    = in_b ? mem[bus.addr_b] : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b && bus.be_b[i] && !(wr_a && same_addr && bus.be_a[i]))
        mem[bus.addr_b][i*BYTE_W +: BYTE_W] <= bus.wdata_b[i*BYTE_W +: BYTE_W];
      if (wr_a && bus.be_a[i])
        mem[bus.addr_a][i*BYTE_W +: BYTE_W] <= bus.wdata_a[i*BYTE_W +: BYTE_W];
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_a, par_b;

  assign par_a = in_a ? par_mem[bus.addr_a] : '0;
  assign par_b = in_b ? par_mem[bus.addr_b] : '0;

  // perr_inj_a corrupts byte 0 parity of port A writes for fault testing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_b && bus.be_b[i] && !(wr_a && same_addr && bus.be_a[i]))
        par_mem[bus.addr_b][i] <= byte_parity(bus.wdata_b[i*BYTE_W +: BYTE_W]);
      if (wr_a && bus.be_a[i])
        par_mem[bus.addr_a][i] <= byte_parity(bus.wdata_a[i*BYTE_W +: BYTE_W])
                                  ^ ((i == 0) && bus.perr_inj_a);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) bus.coll <= 1'b0;
    else        bus.coll <= wr_a && wr_b && same_addr;
  end

  dpram_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .re       (bus.re_a),
    .acc      (bus.re_a || bus.we_a),
    .in_range (in_a),
    .raddr    (bus.addr_a),
    .mem_word (word_a),
`ifdef DPRAM_PARITY_EN
    .mem_par  (par_a),
    .perr     (bus.perr_a),
`endif
    .wr_a     (wr_a),
    .waddr_a  (bus.addr_a),
    .wdata_a  (bus.wdata_a),
    .be_a     (bus.be_a),
    .wr_b     (wr_b),
    .waddr_b  (bus.addr_b),
    .wdata_b  (bus.wdata_b),
    .be_b     (bus.be_b),
    .rdata    (bus.rdata_a),
    .rvalid   (bus.rvalid_a),
    .oob      (bus.oob_a)
  );

  dpram_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .re       (bus.re_b),
    .acc      (bus.re_b || bus.we_b),
    .in_range (in_b),
    .raddr    (bus.addr_b),
    .mem_word (word_b),
`ifdef DPRAM_PARITY_EN
    .mem_par  (par_b),
    .perr     (bus.perr_b),
`endif
    .wr_a     (wr_a),
    .waddr_a  (bus.addr_a),
    .wdata_a  (bus.wdata_a),
    .be_a     (bus.be_a),
    .wr_b     (wr_b),
    .waddr_b  (bus.addr_b),
    .wdata_b  (bus.wdata_b),
    .be_b     (bus.be_b),
    .rdata    (bus.rdata_b),
    .rvalid   (bus.rvalid_b),
    .oob      (bus.oob_b)
  );

endmodule

// File: tb/tb_dpram_param.sv
// Table-driven bench for dpram_param (DEPTH=24 so out-of-range addresses exist);
// parity sequences are built when DPRAM_PARITY_EN is defined.
module tb_dpram_param;
  import dpram_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 24;
  localparam int EW  = 2*DW + 7;

  localparam logic          Y  = 1'b1;
  localparam logic          N  = 1'b0;
  localparam logic [3:0]    F  = 4'hF;
  localparam logic [3:0]    H0 = 4'h0;
  localparam logic [DW-1:0] Z  = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dpram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dpram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic we_a; logic [AW-1:0] addr_a; logic [DW-1:0] wdata_a; logic [3:0] be_a; logic re_a;
    logic we_b; logic [AW-1:0] addr_b; logic [DW-1:0] wdata_b; logic [3:0] be_b; logic re_b;
    logic [DW-1:0] exp_ra; logic exp_va; logic [DW-1:0] exp_rb; logic exp_vb;
    logic exp_coll; logic exp_oa; logic exp_ob;
  } vec_t;

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t row(
    input logic we_a, input logic [AW-1:0] aa, input logic [DW-1:0] wa, input logic [3:0] bea, input logic re_a,
    input logic we_b, input logic [AW-1:0] ab, input logic [DW-1:0] wb, input logic [3:0] beb, input logic re_b,
    input logic [DW-1:0] era, input logic eva, input logic [DW-1:0] erb, input logic evb,
    input logic ec, input logic eoa, input logic eob);
    vec_t v;
    v.we_a = we_a; v.addr_a = aa; v.wdata_a = wa; v.be_a = bea; v.re_a = re_a;
    v.we_b = we_b; v.addr_b = ab; v.wdata_b = wb; v.be_b = beb; v.re_b = re_b;
    v.exp_ra = era; v.exp_va = eva; v.exp_rb = erb; v.exp_vb = evb;
    v.exp_coll = ec; v.exp_oa = eoa; v.exp_ob = eob;
    return v;
  endfunction

  // Layout: rdata_a, rvalid_a, rdata_b, rvalid_b, coll, oob_a, oob_b, perr_a, perr_b
  function automatic logic [EW-1:0] pack_exp(input vec_t v);
    return {v.exp_ra, v.exp_va, v.exp_rb, v.exp_vb, v.exp_coll, v.exp_oa, v.exp_ob, 2'b00};
  endfunction

  function automatic logic [EW-1:0] sample_out();
    logic [1:0] perr;
`ifdef DPRAM_PARITY_EN
    perr = {bus.perr_a, bus.perr_b};
`else
    perr = 2'b00;
`endif
    return {bus.rdata_a, bus.rvalid_a, bus.rdata_b, bus.rvalid_b, bus.coll, bus.oob_a, bus.oob_b, perr};
  endfunction

  task automatic drive(input vec_t v);
    bus.we_a = v.we_a; bus.addr_a = v.addr_a; bus.wdata_a = v.wdata_a; bus.be_a = v.be_a; bus.re_a = v.re_a;
    bus.we_b = v.we_b; bus.addr_b = v.addr_b; bus.wdata_b = v.wdata_b; bus.be_b = v.be_b; bus.re_b = v.re_b;
  endtask

  task automatic check_out(input string name);
    logic [EW-1:0] exp, act;
    @(posedge clk);
    #1;
    act = sample_out();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v);
    exp_q.push_back(pack_exp(v));
    check_out(name);
  endtask

  vec_t          vecs[23];
  vec_t          v, idle;
  logic [DW-1:0] rnd_data[8];
  logic [EW-1:0] e;
  int            idx;

  initial begin
`ifdef DPRAM_PARITY_EN
    bus.perr_inj_a = 1'b0;
`endif
    idle = row(N,5'd0,Z,H0,N, N,5'd0,Z,H0,N, Z,N,Z,N,N,N,N);

    // Reset with live write/read requests on both ports: outputs stay 0.
    rst_n = 1'b0;
    v = row(Y,5'd1,32'hDEADBEEF,F,Y, Y,5'd1,32'hDEADBEEF,F,Y, Z,N,Z,N,N,N,N);
    apply(v, "reset0");
    apply(v, "reset1");
    rst_n = 1'b1;

    vecs[0]  = row(Y,5'd3,32'h11223344,F,N,  N,5'd0,Z,H0,N,             Z,N,Z,N,N,N,N);
    vecs[1]  = row(N,5'd0,Z,H0,N,            N,5'd3,Z,H0,Y,             Z,N,32'h11223344,Y,N,N,N);
    vecs[2]  = idle;
    vecs[3]  = row(Y,5'd5,32'hAABBCCDD,F,N,  N,5'd0,Z,H0,N,             Z,N,Z,N,N,N,N);
    vecs[4]  = row(Y,5'd5,32'h00000011,4'h1,N, N,5'd0,Z,H0,N,           Z,N,Z,N,N,N,N);
    vecs[5]  = row(N,5'd5,Z,H0,Y,            N,5'd0,Z,H0,N,             32'hAABBCC11,Y,Z,N,N,N,N);
    vecs[6]  = row(Y,5'd7,32'h12345678,F,N,  Y,5'd7,32'hFFFFFFFF,F,Y,   Z,N,32'h12345678,Y,Y,N,N);
    vecs[7]  = row(N,5'd7,Z,H0,Y,            N,5'd0,Z,H0,N,             32'h12345678,Y,Z,N,N,N,N);
    vecs[8]  = row(Y,5'd9,32'hCAFEF00D,F,N,  N,5'd9,Z,H0,Y,             Z,N,32'hCAFEF00D,Y,N,N,N);
    vecs[9]  = row(Y,5'd10,32'h01020304,F,N, N,5'd0,Z,H0,N,             Z,N,Z,N,N,N,N);
    vecs[10] = row(Y,5'd10,32'hFFFFAAAA,4'h2,Y, N,5'd0,Z,H0,N,          32'h0102AA04,Y,Z,N,N,N,N);
    vecs[11] = row(Y,5'd11,32'h11111111,4'h3,Y, Y,5'd11,32'h22222222,4'hE,Y, 32'h22221111,Y,32'h22221111,Y,Y,N,N);
    vecs[12] = row(N,5'd0,Z,H0,N,            N,5'd11,Z,H0,Y,            Z,N,32'h22221111,Y,N,N,N);
    vecs[13] = row(N,5'd30,Z,H0,Y,           Y,5'd25,32'hFFFFFFFF,F,Y,  Z,Y,Z,Y,N,Y,Y);
    vecs[14] = row(Y,5'd28,32'h55555555,F,N, N,5'd0,Z,H0,N,             Z,N,Z,N,N,Y,N);
    vecs[15] = row(N,5'd3,Z,H0,Y,            N,5'd5,Z,H0,Y,             32'h11223344,Y,32'hAABBCC11,Y,N,N,N);
    vecs[16] = row(N,5'd3,Z,H0,Y,            Y,5'd3,32'h0000EE00,4'h2,N, 32'h1122EE44,Y,Z,N,N,N,N);
    vecs[17] = row(N,5'd3,Z,H0,Y,            N,5'd0,Z,H0,N,             32'h1122EE44,Y,Z,N,N,N,N);
    vecs[18] = row(Y,5'd20,32'h0A0A0A0A,F,N, Y,5'd21,32'h0B0B0B0B,F,N,  Z,N,Z,N,N,N,N);
    vecs[19] = row(N,5'd21,Z,H0,Y,           N,5'd20,Z,H0,Y,            32'h0B0B0B0B,Y,32'h0A0A0A0A,Y,N,N,N);
    vecs[20] = row(Y,5'd23,32'h9999AAAA,F,N, N,5'd24,Z,H0,Y,            Z,N,Z,Y,N,N,Y);
    vecs[21] = row(N,5'd23,Z,H0,Y,           N,5'd0,Z,H0,N,             32'h9999AAAA,Y,Z,N,N,N,N);
    vecs[22] = idle;

    for (int i = 0; i < 23; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Random fill of 12..19 through A, random-order readback through B.
    for (int k = 0; k < 8; k++) begin
      rnd_data[k] = $urandom;
      v = row(Y,AW'(12+k),rnd_data[k],F,N, N,5'd0,Z,H0,N, Z,N,Z,N,N,N,N);
      apply(v, $sformatf("rnd_wr%0d", k));
    end
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, 7);
      v = row(N,5'd0,Z,H0,N, N,AW'(12+idx),Z,H0,Y, Z,N,rnd_data[idx],Y,N,N,N);
      apply(v, $sformatf("rnd_rd%0d", k));
    end

    // The write driven during reset must not have reached the array.
    drive(row(N,5'd1,Z,H0,Y, N,5'd0,Z,H0,N, Z,N,Z,N,N,N,N));
    @(posedge clk);
    #1;
    checks++;
    if (bus.rdata_a === 32'hDEADBEEF || bus.rvalid_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_write: got rdata_a=%h rvalid_a=%b, required rdata_a!=deadbeef rvalid_a=1",
               bus.rdata_a, bus.rvalid_a);
    end
    drive(idle);
    @(posedge clk);

`ifdef DPRAM_PARITY_EN
    // Injected parity write to addr 2; B reads it in the same cycle (forwarded, clean).
    v = row(Y,5'd2,32'h5A5A5A5A,F,N, N,5'd2,Z,H0,Y, Z,N,32'h5A5A5A5A,Y,N,N,N);
    bus.perr_inj_a = 1'b1;
    apply(v, "par_inj_fwd");
    bus.perr_inj_a = 1'b0;
    v = row(N,5'd2,Z,H0,Y, N,5'd0,Z,H0,N, 32'h5A5A5A5A,Y,Z,N,N,N,N);
    e = pack_exp(v);
    e[1] = 1'b1;
    drive(v);
    exp_q.push_back(e);
    check_out("par_err_a");
    v = row(N,5'd0,Z,H0,N, N,5'd2,Z,H0,Y, Z,N,32'h5A5A5A5A,Y,N,N,N);
    e = pack_exp(v);
    e[0] = 1'b1;
    drive(v);
    exp_q.push_back(e);
    check_out("par_err_b");
    apply(row(Y,5'd4,32'h5A5A5A5B,F,N, N,5'd0,Z,H0,N, Z,N,Z,N,N,N,N), "par_clean_wr");
    apply(row(N,5'd4,Z,H0,Y, N,5'd30,Z,H0,Y, 32'h5A5A5A5B,Y,Z,Y,N,N,Y), "par_clean_rd");
`endif

    apply(idle, "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
